// File: rtl/seq_mult_8x8_ctrl_if.sv
// Bus bundle between the multiplier sequencer, its host and the downstream 16-bit adder.
// The host drives the master side. The sequencer uses the slave side.
interface seq_mult_8x8_ctrl_if;
    logic        start;
    logic [7:0]  dataa_in;
    logic [7:0]  datab_in;
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic [15:0] adder_sum;
    logic [15:0] product;
    logic        busy;
    logic        done;

    modport master (
        output start, dataa_in, datab_in, adder_sum,
        input  adder_a, adder_b, product, busy, done
    );

    modport slave (
        input  start, dataa_in, datab_in, adder_sum,
        output adder_a, adder_b, product, busy, done
    );
endinterface

// File: rtl/seq_mult_8x8_ctrl.sv
// Sequential 8x8 unsigned multiplier. Four nibble partial products are accumulated
// through an external 16-bit combinational adder, one per cycle, over CALC0..CALC3.
module seq_mult_8x8_ctrl (
    input  logic                  clk,
    input  logic                  reset_n,
    seq_mult_8x8_ctrl_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC0 = 3'd1,
        S_CALC1 = 3'd2,
        S_CALC2 = 3'd3,
        S_CALC3 = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_calc;
    logic        w_busy_next;
    logic [3:0]  w_nib_a;
    logic [3:0]  w_nib_b;
    logic [3:0]  w_shift;
    logic [7:0]  w_pp;
    logic [15:0] w_pp_shifted;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_acc   <= 16'h0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_a   <= bus.dataa_in;
                r_b   <= bus.datab_in;
                r_acc <= 16'h0000;
            end else if (w_calc) begin
                r_acc <= bus.adder_sum;
            end
        end
    end

    // Next state plus the nibble selection and shift amount for the current CALC step.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_calc       = 1'b0;
        w_nib_a      = 4'h0;
        w_nib_b      = 4'h0;
        w_shift      = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CALC0;
                end
            end
            S_CALC0: begin
                w_calc       = 1'b1;
                w_nib_a      = r_a[3:0];
                w_nib_b      = r_b[3:0];
                w_shift      = 4'd0;
                w_state_next = S_CALC1;
            end
            S_CALC1: begin
                w_calc       = 1'b1;
                w_nib_a      = r_a[7:4];
                w_nib_b      = r_b[3:0];
                w_shift      = 4'd4;
                w_state_next = S_CALC2;
            end
            S_CALC2: begin
                w_calc       = 1'b1;
                w_nib_a      = r_a[3:0];
                w_nib_b      = r_b[7:4];
                w_shift      = 4'd4;
                w_state_next = S_CALC3;
            end
            S_CALC3: begin
                w_calc       = 1'b1;
                w_nib_a      = r_a[7:4];
                w_nib_b      = r_b[7:4];
                w_shift      = 4'd8;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CALC0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        w_busy_next = (w_state_next == S_CALC0) || (w_state_next == S_CALC1) ||
                      (w_state_next == S_CALC2) || (w_state_next == S_CALC3);
    end

    assign w_pp         = {4'h0, w_nib_a} * {4'h0, w_nib_b};
    // Outside CALC the nibbles are zero, so adder_a is 0 and adder_sum mirrors product.
    assign w_pp_shifted = {8'h00, w_pp} << w_shift;

    assign bus.adder_a = w_pp_shifted;
    assign bus.adder_b = r_acc;
    assign bus.product = r_acc;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule
